gc_dispenser: RTL

- Parametrised global-counter (loop-index) dispenser shared by `N_CORE` cores.
- Hands each requesting core a distinct index `gc + k*gd` per cycle using prefix-sum allocation.
- Adds an optional exclusive bound with exhaustion detection and a registered join on child-core `ending`.
- Sits in `top` between the fork-issuing parent core and the core array; it is the bounded successor of the inline counter logic.

---
 rtl/gc_dispenser_pkg.sv | 18 +
 rtl/gc_prefix_alloc.sv | 100 ++++++++++
 rtl/gc_dispenser.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gc_dispenser_pkg.sv
// Shared types and default sizing for the global-counter dispenser.
//   N_CORE_DEF   : default number of cores (core 0 is the parent)
//   GC_WIDTH_DEF : default signed index width
//   GD_WIDTH_DEF : default signed stride width
//   gcd_state_t  : dispenser FSM state encoding
package gc_dispenser_pkg;

  localparam int unsigned N_CORE_DEF   = 4;
  localparam int unsigned GC_WIDTH_DEF = 32;
  localparam int unsigned GD_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gc_prefix_alloc.sv
// Combinational prefix-sum allocator for the global-counter dispenser.
// Each core i is offered gc + k_i*gd, where k_i counts the requesters below
// it. Arithmetic is carried in a widened signed domain so candidates never
// wrap before the range test.
// Ports:
//   gc, gd, limit, bounded : current loop registers
//   req_valid              : per-core request vector
//   fork_*                 : incoming fork values (start range test)
//   cand                   : low GC_WIDTH bits of each core's candidate
//   in_range_vec           : per-core candidate range test result
//   next_gc                : gc advanced by the number of granted requests
//   next_in_range          : range test of the advanced (unwrapped) gc
//   fork_in_range          : range test of fork_gc under the fork settings
module gc_prefix_alloc
  import gc_dispenser_pkg::*;
#(
  parameter int unsigned N_CORE   = N_CORE_DEF,
  parameter int unsigned GC_WIDTH = GC_WIDTH_DEF,
  parameter int unsigned GD_WIDTH = GD_WIDTH_DEF
) (
  input  logic signed [GC_WIDTH-1:0]             gc,
  input  logic signed [GD_WIDTH-1:0]             gd,
  input  logic signed [GC_WIDTH-1:0]             limit,
  input  logic                                   bounded,
  input  logic        [N_CORE-1:0]               req_valid,
  input  logic signed [GC_WIDTH-1:0]             fork_gc,
  input  logic signed [GD_WIDTH-1:0]             fork_gd,
  input  logic signed [GC_WIDTH-1:0]             fork_limit,
  input  logic                                   fork_bounded,
  output logic        [N_CORE-1:0][GC_WIDTH-1:0] cand,
  output logic        [N_CORE-1:0]               in_range_vec,
  output logic        [GC_WIDTH-1:0]             next_gc,
  output logic                                   next_in_range,
  output logic                                   fork_in_range
);

  localparam int unsigned KW = $clog2(N_CORE + 1);
  localparam int unsigned CW = GC_WIDTH + GD_WIDTH + KW;

  // Exclusive bound in the direction of the stride; zero stride never fits.
  function automatic logic in_range(input logic signed [CW-1:0]       c,
                                    input logic signed [CW-1:0]       lim,
                                    input logic signed [GD_WIDTH-1:0] step,
                                    input logic                       bnd);
    logic r;
    if (!bnd) begin
      r = 1'b1;
    end else if (step == '0) begin
      r = 1'b0;
    end else if (step[GD_WIDTH-1]) begin
      r = (c > lim);
    end else begin
      r = (c < lim);
    end
    return r;
  endfunction

  logic signed [CW-1:0] gc_x;
  logic signed [CW-1:0] gd_x;
  logic signed [CW-1:0] lim_x;
  logic signed [CW-1:0] fgc_x;
  logic signed [CW-1:0] flim_x;
  logic signed [CW-1:0] next_full;

  // Sign-extend everything into the no-wrap domain.
  assign gc_x   = {{(CW-GC_WIDTH){gc[GC_WIDTH-1]}}, gc};
  assign gd_x   = {{(CW-GD_WIDTH){gd[GD_WIDTH-1]}}, gd};
  assign lim_x  = {{(CW-GC_WIDTH){limit[GC_WIDTH-1]}}, limit};
  assign fgc_x  = {{(CW-GC_WIDTH){fork_gc[GC_WIDTH-1]}}, fork_gc};
  assign flim_x = {{(CW-GC_WIDTH){fork_limit[GC_WIDTH-1]}}, fork_limit};

  // Prefix counts, candidates and grant count in one ordered pass.
  always_comb begin : alloc
    logic [KW-1:0]        k;
    logic [KW-1:0]        g;
    logic signed [CW-1:0] c;
    k            = '0;
    g            = '0;
    c            = '0;
    cand         = '0;
    in_range_vec = '0;
    for (int i = 0; i < N_CORE; i++) begin
      c               = gc_x + gd_x * $signed({{(CW-KW){1'b0}}, k});
      cand[i]         = c[GC_WIDTH-1:0];
      in_range_vec[i] = in_range(c, lim_x, gd, bounded);
      if (req_valid[i]) begin
        if (in_range_vec[i]) begin
          g = g + KW'(1);
        end
        k = k + KW'(1);
      end
    end
    next_full = gc_x + gd_x * $signed({{(CW-KW){1'b0}}, g});
  end

  assign next_gc       = next_full[GC_WIDTH-1:0];
  assign next_in_range = in_range(next_full, lim_x, gd, bounded);
  assign fork_in_range = in_range(fgc_x, flim_x, fork_gd, fork_bounded);

endmodule

// File: rtl/gc_dispenser.sv
// Global-counter (loop-index) dispenser shared by N_CORE cores.
// Hands each requesting core a distinct index gc + k*gd per cycle, supports
// an optional exclusive bound with exhaustion, and joins on child ending.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   issue_fork        : load a new loop (priority over requests)
//   fork_gc/gd/limit  : start index, stride, exclusive bound
//   fork_bounded      : 1 = bounded loop, 0 = unbounded (wraps)
//   req_valid         : per-core index request
//   req_ready         : per-core grant (combinational)
//   gc_assign         : per-core index, valid while req_ready[i]
//   ending            : per-core idle flag, bit 0 ignored
//   exhausted         : bounded loop has run out of indices
//   all_ending        : registered AND of ending[N_CORE-1:1]
//   done              : one-cycle pulse when the loop is complete
//   busy              : FSM not idle
module gc_dispenser
  import gc_dispenser_pkg::*;
#(
  parameter int unsigned N_CORE   = N_CORE_DEF,
  parameter int unsigned GC_WIDTH = GC_WIDTH_DEF,
  parameter int unsigned GD_WIDTH = GD_WIDTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   issue_fork,
  input  logic signed [GC_WIDTH-1:0]             fork_gc,
  input  logic signed [GD_WIDTH-1:0]             fork_gd,
  input  logic signed [GC_WIDTH-1:0]             fork_limit,
  input  logic                                   fork_bounded,
  input  logic        [N_CORE-1:0]               req_valid,
  output logic        [N_CORE-1:0]               req_ready,
  output logic        [N_CORE-1:0][GC_WIDTH-1:0] gc_assign,
  input  logic        [N_CORE-1:0]               ending,
  output logic                                   exhausted,
  output logic                                   all_ending,
  output logic                                   done,
  output logic                                   busy
);

  gcd_state_t                 state;
  gcd_state_t                 state_next;
  logic signed [GC_WIDTH-1:0] gc;
  logic signed [GD_WIDTH-1:0] gd;
  logic signed [GC_WIDTH-1:0] limit;
  logic                       bounded;

  logic [N_CORE-1:0]   in_range_vec;
  logic [GC_WIDTH-1:0] next_gc;
  logic                next_in_range;
  logic                fork_in_range;
  logic                run_exhaust;
  logic                ending_unused;

  // The parent's own ending flag plays no part in the join.
  assign ending_unused = ending[0];

  gc_prefix_alloc #(
    .N_CORE   (N_CORE),
    .GC_WIDTH (GC_WIDTH),
    .GD_WIDTH (GD_WIDTH)
  ) u_alloc (
    .gc            (gc),
    .gd            (gd),
    .limit         (limit),
    .bounded       (bounded),
    .req_valid     (req_valid),
    .fork_gc       (fork_gc),
    .fork_gd       (fork_gd),
    .fork_limit    (fork_limit),
    .fork_bounded  (fork_bounded),
    .cand          (gc_assign),
    .in_range_vec  (in_range_vec),
    .next_gc       (next_gc),
    .next_in_range (next_in_range),
    .fork_in_range (fork_in_range)
  );

  // Bounded loop runs dry after this cycle's grants.
  assign run_exhaust = (state == RUN) && bounded && !next_in_range;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a fork wins in every state.
  always_comb begin
    state_next = state;
    if (issue_fork) begin
      state_next = fork_in_range ? RUN : DRAIN;
    end else begin
      case (state)
        RUN: begin
          if (run_exhaust) begin
            state_next = DRAIN;
          end
        end
        DRAIN: begin
          if (all_ending) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  // Output logic: grants only in RUN and never in a fork cycle.
  always_comb begin
    req_ready = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    if ((state == RUN) && !issue_fork) begin
      req_ready = in_range_vec;
    end
    if ((state == DRAIN) && all_ending && !issue_fork) begin
      done = 1'b1;
    end
  end

  // Loop registers and exhaustion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gc        <= '0;
      gd        <= '0;
      limit     <= '0;
      bounded   <= 1'b0;
      exhausted <= 1'b0;
    end else if (issue_fork) begin
      gc        <= fork_gc;
      gd        <= fork_gd;
      limit     <= fork_limit;
      bounded   <= fork_bounded;
      exhausted <= !fork_in_range;
    end else begin
      case (state)
        RUN: begin
          gc <= next_gc;
          if (run_exhaust) begin
            exhausted <= 1'b1;
          end
        end
        DRAIN: begin
          if (all_ending) begin
            exhausted <= 1'b0;
          end
        end
        default: begin
          gc <= gc;
        end
      endcase
    end
  end

  // Join on the child cores; a lone parent is always joined.
  if (N_CORE > 1) begin : g_join
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        all_ending <= 1'b0;
      end else begin
        all_ending <= &ending[N_CORE-1:1];
      end
    end
  end else begin : g_solo
    assign all_ending = 1'b1;
  end

endmodule
